// File: rtl/fila_bridge.sv
// ---------------------------------------------------------------------------
// fila_bridge
//   Queue-plus-handshake bridge between the 100 kHz deserializer and the
//   consumer. It runs the four-phase data_ready/ack_in handshake, brings the
//   cross-domain control inputs into clk_10KHz and stores the words in a
//   circular FIFO. When the FIFO is full it either applies backpressure or
//   acknowledges the word and drops it, depending on DROP_WHEN_FULL.
//
// Parameters
//   DATA_W         word width
//   DEPTH          FIFO entries (>= 2, any value)
//   DROP_WHEN_FULL 0: withhold ack while full, 1: ack and discard when full
//   LEN_W          width of len_out
//
// Ports
//   clk_10KHz   in   clock
//   reset       in   asynchronous, active-high reset
//   data_in     in   word from the deserializer, stable while data_ready=1
//   data_ready  in   word valid (100 kHz domain, synchronised here)
//   ack_in      out  handshake acknowledge to the deserializer
//   dequeue_in  in   pop request, asynchronous level (one pop per rising edge)
//   data_out    out  last popped word
//   len_out     out  current occupancy, 0..DEPTH
//   full        out  len_out == DEPTH
//   empty       out  len_out == 0
//   drop_count  out  words discarded in drop mode, saturates at 255
//   underflow   out  one-cycle pulse on a pop request while empty
// ---------------------------------------------------------------------------
module fila_bridge #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 8,
  parameter bit DROP_WHEN_FULL = 1'b0,
  parameter int LEN_W          = $clog2(DEPTH + 1)
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_ready,
  output logic              ack_in,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              full,
  output logic              empty,
  output logic [7:0]        drop_count,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Synchroniser and history flops
  logic r_dr_s1;
  logic r_dr_s2;
  logic r_dq_s1;
  logic r_dq_s2;
  logic r_dq_s3;

  // Handshake and queue state
  state_t            r_state;
  logic              r_ack;
  logic [7:0]        r_drop_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_data_out;
  logic              r_underflow;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Combinational decode
  logic             w_dr_s;
  logic             w_pop_req;
  logic             w_pop_ok;
  logic             w_wr_en;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  // Decode of the handshake/pop events and the wrapped pointer successors
  always_comb begin
    w_dr_s    = r_dr_s2;
    w_full    = (r_len == LEN_W'(DEPTH));
    w_empty   = (r_len == {LEN_W{1'b0}});
    w_pop_req = r_dq_s2 & ~r_dq_s3;
    w_pop_ok  = w_pop_req & ~w_empty;
    w_wr_en   = 1'b0;
    w_drop    = 1'b0;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    if ((r_state == ST_IDLE) && w_dr_s) begin
      if (!w_full || w_pop_ok) begin
        w_wr_en = 1'b1;
      end else if (DROP_WHEN_FULL) begin
        w_drop = 1'b1;
      end else begin
        w_drop = 1'b0;
      end
    end else begin
      w_wr_en = 1'b0;
    end
    // Explicit wrap so non power-of-two depths work.
    if (r_wr_ptr == PTR_W'(DEPTH - 1)) begin
      w_wr_ptr_nxt = {PTR_W{1'b0}};
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    end
    if (r_rd_ptr == PTR_W'(DEPTH - 1)) begin
      w_rd_ptr_nxt = {PTR_W{1'b0}};
    end else begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
    end
  end

  // Two-flop synchronisers; the dequeue path keeps a history flop for edge detect
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_dr_s1 <= 1'b0;
      r_dr_s2 <= 1'b0;
      r_dq_s1 <= 1'b0;
      r_dq_s2 <= 1'b0;
      r_dq_s3 <= 1'b0;
    end else begin
      r_dr_s1 <= data_ready;
      r_dr_s2 <= r_dr_s1;
      r_dq_s1 <= dequeue_in;
      r_dq_s2 <= r_dq_s1;
      r_dq_s3 <= r_dq_s2;
    end
  end

  // Handshake FSM: one word accepted (or dropped) per data_ready high phase
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_en || w_drop) begin
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end else begin
              r_drop_cnt <= r_drop_cnt;
            end
          end else begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (!w_dr_s) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pointers, occupancy, popped word and underflow pulse
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_len       <= {LEN_W{1'b0}};
      r_data_out  <= {DATA_W{1'b0}};
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= w_rd_ptr_nxt;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_en, w_pop_ok})
        2'b10:   r_len <= r_len + LEN_W'(1);
        2'b01:   r_len <= r_len - LEN_W'(1);
        default: r_len <= r_len;
      endcase
      r_underflow <= w_pop_req & w_empty;
    end
  end

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk_10KHz) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  assign ack_in     = r_ack;
  assign data_out   = r_data_out;
  assign len_out    = r_len;
  assign full       = w_full;
  assign empty      = w_empty;
  assign drop_count = r_drop_cnt;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_fila_bridge.sv
`timescale 1ns/1ps
module tb_fila_bridge;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic       reset;
  logic [7:0] din [2];
  logic       dr  [2];
  logic       dq  [2];

  // Instance 0: DEPTH=8 backpressure; instance 1: DEPTH=5 drop mode
  logic       ack0, full0, empty0, uf0;
  logic [7:0] dout0, dcnt0;
  logic [3:0] len0;
  logic       ack1, full1, empty1, uf1;
  logic [7:0] dout1, dcnt1;
  logic [2:0] len1;

  int n_checks = 0;
  int n_fail   = 0;

  fila_bridge #(.DATA_W(8), .DEPTH(8), .DROP_WHEN_FULL(1'b0)) dut0 (
    .clk_10KHz(clk), .reset(reset), .data_in(din[0]), .data_ready(dr[0]),
    .ack_in(ack0), .dequeue_in(dq[0]), .data_out(dout0), .len_out(len0),
    .full(full0), .empty(empty0), .drop_count(dcnt0), .underflow(uf0)
  );

  fila_bridge #(.DATA_W(8), .DEPTH(5), .DROP_WHEN_FULL(1'b1)) dut1 (
    .clk_10KHz(clk), .reset(reset), .data_in(din[1]), .data_ready(dr[1]),
    .ack_in(ack1), .dequeue_in(dq[1]), .data_out(dout1), .len_out(len1),
    .full(full1), .empty(empty1), .drop_count(dcnt1), .underflow(uf1)
  );

  function automatic logic get_ack(input int i);
    return (i == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [7:0] get_dout(input int i);
    return (i == 0) ? dout0 : dout1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int i, input logic val, input int budget, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (get_ack(i) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] w);
    logic ok;
    din[i] = w;
    dr[i]  = 1'b1;
    wait_ack(i, 1'b1, 10, ok);
    check("push_ack", ok, 1);
    dr[i] = 1'b0;
    wait_ack(i, 1'b0, 10, ok);
    check("push_release", ok, 1);
  endtask

  task automatic pop(input int i, output logic [7:0] d);
    dq[i] = 1'b1;
    repeat (3) @(negedge clk);
    d     = get_dout(i);
    dq[i] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       ok;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din[i] = 8'h00;
      dr[i]  = 1'b0;
      dq[i]  = 1'b0;
    end

    // Reset values before any clock edge
    #10;
    check("rst_ack", ack0, 0);
    check("rst_len", len0, 0);
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_dout", dout0, 0);
    check("rst_uf", uf0, 0);
    check("rst_dcnt", dcnt1, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single transfer with exact edge timing
    @(negedge clk);
    din[0] = 8'hA5;
    dr[0]  = 1'b1;
    repeat (2) @(negedge clk);
    check("st_ack_edge2", ack0, 0);
    @(negedge clk);
    check("st_ack_edge3", ack0, 1);
    check("st_len", len0, 1);
    dr[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("st_rel_edge2", ack0, 1);
    @(negedge clk);
    check("st_rel_edge3", ack0, 0);
    dq[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("st_pop_edge2_len", len0, 1);
    @(negedge clk);
    check("st_pop_dout", dout0, 8'hA5);
    check("st_pop_len", len0, 0);
    check("st_pop_empty", empty0, 1);
    dq[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure: fill, stall the 9th word, free one slot, drain with wrap
    for (int k = 1; k <= 8; k++) push(0, 8'(k));
    check("bp_full", full0, 1);
    check("bp_len8", len0, 8);
    din[0] = 8'h09;
    dr[0]  = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_stall_ack", ack0, 0);
    check("bp_stall_len", len0, 8);
    dq[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_pop_dout", dout0, 8'h01);
    check("bp_pop_ack", ack0, 1);
    check("bp_pop_len", len0, 8);
    dq[0] = 1'b0;
    dr[0] = 1'b0;
    wait_ack(0, 1'b0, 10, ok);
    check("bp_release", ok, 1);
    repeat (3) @(negedge clk);
    for (int k = 2; k <= 9; k++) begin
      pop(0, d);
      check("bp_drain", d, k);
    end
    check("bp_empty", empty0, 1);

    // Drop mode: 7 words into 5 entries
    for (int k = 0; k < 7; k++) push(1, 8'h11 + 8'(k));
    check("drop_len", len1, 5);
    check("drop_cnt", dcnt1, 2);
    check("drop_full", full1, 1);
    for (int k = 0; k < 5; k++) begin
      pop(1, d);
      check("drop_drain", d, 8'h11 + 8'(k));
    end
    check("drop_empty", empty1, 1);

    // Simultaneous push and pop at occupancy 3
    push(0, 8'h21);
    push(0, 8'h22);
    push(0, 8'h23);
    din[0] = 8'h24;
    dr[0]  = 1'b1;
    dq[0]  = 1'b1;
    repeat (3) @(negedge clk);
    check("sim_len", len0, 3);
    check("sim_dout", dout0, 8'h21);
    check("sim_ack", ack0, 1);
    dq[0] = 1'b0;
    dr[0] = 1'b0;
    wait_ack(0, 1'b0, 10, ok);
    check("sim_release", ok, 1);
    repeat (3) @(negedge clk);

    // Underflow on the empty drop-mode instance
    dq[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("uf_before", uf1, 0);
    @(negedge clk);
    check("uf_pulse", uf1, 1);
    check("uf_dout_hold", dout1, 8'h15);
    check("uf_len", len1, 0);
    dq[1] = 1'b0;
    @(negedge clk);
    check("uf_after", uf1, 0);
    repeat (3) @(negedge clk);

    // Reset while ack_in is high, then the held word is re-accepted
    din[0] = 8'h5C;
    dr[0]  = 1'b1;
    wait_ack(0, 1'b1, 10, ok);
    check("ra_ack_seen", ok, 1);
    check("ra_len4", len0, 4);
    #10;
    reset = 1'b1;
    #1;
    check("ra_ack_async", ack0, 0);
    check("ra_len_async", len0, 0);
    check("ra_empty_async", empty0, 1);
    check("ra_dout_async", dout0, 0);
    check("ra_dcnt_async", dcnt1, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("ra_reacc_edge2", ack0, 0);
    @(negedge clk);
    check("ra_reacc_edge3", ack0, 1);
    check("ra_reacc_len", len0, 1);
    dr[0] = 1'b0;
    wait_ack(0, 1'b0, 10, ok);
    check("ra_release", ok, 1);
    pop(0, d);
    check("ra_pop", d, 8'h5C);
    check("ra_final_empty", empty0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
